adc_iq_decimator: RTL and testbench
===================================

# adc_iq_decimator

Receive-side counterpart to the DAC output path. It captures a pair of 6-bit offset-binary ADC samples (I on `adc_zero`, Q on `adc_one`) at `pll_clock`, removes the offset, and boxcar-averages over 2^LOG2_DECIM samples. Each decimated signed I/Q pair is presented on a valid/ready output port, so the 5-bit complex mixer and NCO datapath can consume captured RF.

## Interface
- `LOG2_DECIM`, default 3: log2 of decimation factor D (D = 8 by default); legal range 1..6.
- `OUT_W`, default 5: output sample width, two's complement; must be ≤ 6+LOG2_DECIM.

- `pll_clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  sample enable; ADC inputs are captured only on edges where it is high.
- `adc_zero`  in  6  I sample, offset binary (32 = zero).
- `adc_one`  in  6  Q sample, offset binary (32 = zero).
- `out_i`  out  OUT_W  decimated I, signed.
- `out_q`  out  OUT_W  decimated Q, signed.
- `out_valid`  out  1  `out_i`/`out_q` hold an untransferred result.
- `out_ready`  in  1  consumer accepts the result on an edge where `out_valid` is also high.
- `overrun`  out  1  sticky flag: a result was dropped due to backpressure.

## Operation
- Stage 1, capture. On an edge with `clk_en`=1:
  - s_i <= adc_zero − 32 as signed 6-bit, i.e. {~adc_zero[5], adc_zero[4:0]}; s_q likewise from adc_one.
  - `s1_valid` <= `clk_en` every edge.
- Stage 2, accumulate. Accumulator width A = 6+LOG2_DECIM, signed; sample counter `cnt` is LOG2_DECIM bits.
  - On an edge with `s1_valid`=1: if cnt==0, acc <= s; else acc <= acc + s. cnt <= cnt+1, wrapping at D.
  - No overflow is possible: |sum| ≤ 32·D fits in A bits.
  - When cnt==D−1, the block completes. The full sum is sum = acc + s; the result is sum[A−1 -: OUT_W], an arithmetic shift right by A−OUT_W (floor, no rounding).
  - `s1_valid`=0: acc and cnt hold.
- Output register and handshake:
  - Transfer occurs on an edge with out_valid && out_ready. That edge clears out_valid, unless a block completes on the same edge.
  - Block completion when out_valid=0, or out_valid=1 with a transfer on the same edge: load out_i/out_q with the new result; out_valid <= 1.
  - Block completion with out_valid=1 and out_ready=0: the new result is discarded, out_i/out_q/out_valid are unchanged, and overrun <= 1.
  - out_i/out_q are stable while out_valid=1 and no transfer has occurred.
  - `out_ready` is ignored while out_valid=0.
  - The handshake operates independently of `clk_en`.
- `overrun` clears only on reset.

## Timing
- Reset values: out_i=0, out_q=0, out_valid=0, overrun=0. Internal state: acc=0, cnt=0, s1_valid=0, s_i=s_q=0.
- Reset asserted mid-block discards the partial sum and any pending output. The first block after reset starts at the first sample captured with reset low.
- Reset has priority over `clk_en` and the handshake.
- Latency: the D-th sample of a block is presented at edge k with clk_en=1, and out_valid is high after edge k+1 (2 edges).
- Throughput: at most one result per D enabled samples. With clk_en constantly high and out_ready high, out_valid is a one-cycle pulse every D cycles.
- No combinational path from any input to any output.

## Test plan
- Reset, then adc_zero=adc_one=32, clk_en=1, out_ready=1 with samples from edge 1. Required: out_valid first high after edge 9, with out_i=out_q=0; out_valid pulses every 8 cycles thereafter; overrun=0.
- Full-scale inputs adc_zero=63, adc_one=0 (D=8, OUT_W=5). Required: sum I=248 gives out_i=15; sum Q=−256 gives out_q=−16; repeated every block.
- Backpressure: out_ready=0 for 20 cycles with constant input. Required: the first result is held unchanged and out_valid stays 1; at the second completion, overrun=1 and out_i/out_q are unchanged. Then out_ready=1: transfer occurs, out_valid drops until the next completion, and overrun stays 1.
- clk_en alternating 1/0, adc_zero=48 (s=16). Required: one result per 16 cycles; out_i = (16·8)>>4 = 8, identical to the continuous-enable value.
- Reset after 5 samples of adc_zero=63, then 8 samples of adc_zero=32. Required: the first post-reset out_i=0 (partial sum discarded), out_valid=0 and overrun=0 during and immediately after reset.
- out_ready raised exactly on a completion edge while the previous result is pending. Required: old result transferred and new result loaded on the same edge, out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/adc_iq_decimator.sv
// adc_iq_decimator
//   Captures offset-binary 6-bit I/Q ADC samples, removes the offset and
//   boxcar-averages each channel over 2**LOG2_DECIM enabled samples. Each
//   decimated signed pair is offered on a valid/ready output register.
//
// Ports
//   pll_clock  in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   clk_en     in   sample enable for adc_zero/adc_one capture
//   adc_zero   in   I sample, offset binary (32 = zero)
//   adc_one    in   Q sample, offset binary (32 = zero)
//   out_i      out  decimated I, two's complement, OUT_W bits
//   out_q      out  decimated Q, two's complement, OUT_W bits
//   out_valid  out  out_i/out_q hold an untransferred result
//   out_ready  in   consumer accepts on an edge where out_valid is high
//   overrun    out  sticky: a completed result was dropped (backpressure)
module adc_iq_decimator #(
    parameter int LOG2_DECIM = 3,
    parameter int OUT_W      = 5
) (
    input  logic             pll_clock,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [5:0]       adc_zero,
    input  logic [5:0]       adc_one,
    output logic [OUT_W-1:0] out_i,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int A = 6 + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    logic signed [5:0]   s_i, s_q;
    logic                s1_valid;
    logic signed [A-1:0] acc_i, acc_q;
    logic signed [A-1:0] ext_i, ext_q;
    logic signed [A-1:0] sum_i, sum_q;
    logic [LOG2_DECIM-1:0] cnt;
    logic                complete;

    // Stage 1: offset removal is just an MSB flip of the offset-binary code.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            s_i      <= '0;
            s_q      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= clk_en;
            if (clk_en) begin
                s_i <= {~adc_zero[5], adc_zero[4:0]};
                s_q <= {~adc_one[5],  adc_one[4:0]};
            end
        end
    end

    // The first sample of a block replaces the accumulator instead of adding.
    always_comb begin
        ext_i    = {{(A-6){s_i[5]}}, s_i};
        ext_q    = {{(A-6){s_q[5]}}, s_q};
        sum_i    = (cnt == '0) ? ext_i : acc_i + ext_i;
        sum_q    = (cnt == '0) ? ext_q : acc_q + ext_q;
        complete = s1_valid && (cnt == CNT_LAST);
    end

    // Stage 2: accumulate; cnt wraps naturally at D.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (s1_valid) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            cnt   <= cnt + 1'b1;
        end
    end

    // Output register: a completion may reload on the same edge as a transfer;
    // a completion against a stalled result is dropped and flagged.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete) begin
            if (!out_valid || out_ready) begin
                out_i     <= sum_i[A-1 -: OUT_W];
                out_q     <= sum_q[A-1 -: OUT_W];
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_iq_decimator.sv
module tb_adc_iq_decimator;

    localparam int LOG2_DECIM = 3;
    localparam int OUT_W      = 5;
    localparam int D          = 1 << LOG2_DECIM;
    localparam int SH         = 6 + LOG2_DECIM - OUT_W;

    logic             pll_clock = 1'b0;
    logic             reset     = 1'b1;
    logic             clk_en    = 1'b0;
    logic [5:0]       adc_zero  = 6'd32;
    logic [5:0]       adc_one   = 6'd32;
    logic [OUT_W-1:0] out_i;
    logic [OUT_W-1:0] out_q;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overrun;

    adc_iq_decimator #(.LOG2_DECIM(LOG2_DECIM), .OUT_W(OUT_W)) dut (
        .pll_clock(pll_clock),
        .reset    (reset),
        .clk_en   (clk_en),
        .adc_zero (adc_zero),
        .adc_one  (adc_one),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 pll_clock = ~pll_clock;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit running      = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel integer sums over D enabled samples,
    // one-edge capture delay, and a single-slot output holding queue.
    typedef struct { int i; int q; } pair_t;
    pair_t exp_q[$];
    bit    m_s1_valid = 0;
    int    m_si = 0, m_sq = 0;
    int    m_sum_i = 0, m_sum_q = 0, m_count = 0;
    bit    m_pending = 0, m_overrun = 0;
    pair_t m_cur = '{0, 0};

    always @(posedge pll_clock) begin
        bit    done;
        pair_t r;
        if (reset) begin
            m_s1_valid = 0; m_si = 0; m_sq = 0;
            m_sum_i = 0; m_sum_q = 0; m_count = 0;
            m_pending = 0; m_overrun = 0;
            m_cur = '{0, 0};
            exp_q.delete();
        end else begin
            done = 0;
            if (m_s1_valid) begin
                m_sum_i += m_si;
                m_sum_q += m_sq;
                m_count++;
                if (m_count == D) begin
                    r.i = m_sum_i >>> SH;
                    r.q = m_sum_q >>> SH;
                    done = 1;
                    m_sum_i = 0; m_sum_q = 0; m_count = 0;
                end
            end
            if (done) begin
                if (!m_pending || out_ready) begin
                    exp_q.push_back(r);
                    m_cur = r;
                    m_pending = 1;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_pending && out_ready) begin
                m_pending = 0;
            end
            m_s1_valid = clk_en;
            if (clk_en) begin
                m_si = int'(adc_zero) - 32;
                m_sq = int'(adc_one) - 32;
            end
        end
    end

    // Monitor: mid-cycle, away from the active edge.
    always @(negedge pll_clock) begin
        pair_t e;
        if (running) begin
            check("out_valid", int'(out_valid), int'(m_pending));
            check("overrun", int'(overrun), int'(m_overrun));
            if (out_valid || reset) begin
                check("out_i_held", int'($signed(out_i)), m_cur.i);
                check("out_q_held", int'($signed(out_q)), m_cur.q);
            end
            if (out_valid && out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_i", int'($signed(out_i)), e.i);
                    check("xfer_q", int'($signed(out_q)), e.q);
                end
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pll_clock);
            #1;
        end
    endtask

    initial begin
        int first;
        bit found;

        // Reset, then zero-valued stream: first result after edge 9.
        step(3);
        reset = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
        adc_zero = 6'd32; adc_one = 6'd32;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (out_valid && first == 0) first = e;
        end
        check("first_valid_edge", first, 9);
        step(12);

        // Full scale: I = +248 -> 15, Q = -256 -> -16.
        adc_zero = 6'd63; adc_one = 6'd0;
        step(24);

        // Backpressure then release.
        out_ready = 1'b0;
        step(20);
        out_ready = 1'b1;
        step(16);

        // Alternating enable, adc_zero = 48.
        adc_zero = 6'd48; adc_one = 6'd16;
        for (int k = 0; k < 40; k++) begin
            clk_en = (k % 2 == 0);
            step(1);
        end
        clk_en = 1'b1;

        // Reset mid-block after 5 full-scale samples.
        adc_zero = 6'd63; adc_one = 6'd63;
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        adc_zero = 6'd32; adc_one = 6'd32;
        step(16);

        // Ready raised exactly on a completion edge with a pending result.
        adc_zero = 6'd50; adc_one = 6'd7;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (out_valid) found = 1;
        end
        check("pending_seen", int'(found), 1);
        out_ready = 1'b0;
        adc_zero = 6'd20; adc_one = 6'd40;
        step(7);
        out_ready = 1'b1;
        step(1);
        check("same_edge_valid", int'(out_valid), 1);
        check("same_edge_overrun", int'(overrun), 0);
        step(10);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            adc_zero  = 6'($urandom_range(0, 63));
            adc_one   = 6'($urandom_range(0, 63));
            clk_en    = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            reset     = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        step(4);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
